// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
//   md_state_t  MUL/DIV sequencer state
//   *_DEF       default latencies and busy-counter width
//   REG_ZERO    the hardwired-zero register, never a hazard source
package hazard_pkg;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF = 6;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: tracks the background MUL/DIV unit with a busy down-counter.
//   clk, rst_n  clock, async active-low reset (abandons any op in flight)
//   start       EX accepts a mul/div this cycle
//   is_div      qualifies start: 1=div, 0=mul
//   busy        unit computing
//   done        one-cycle pulse in the last busy cycle; HI/LO valid next cycle
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  md_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // A new start always wins: it reloads even mid-op or in the done cycle.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (start) begin
      state_n = MD_BUSY;
      cnt_n = is_div ? DIV_LOAD : MUL_LOAD;
    end else if (state == MD_BUSY) begin
      state_n = cnt == '0 ? MD_IDLE : MD_BUSY;
      cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
    end
  end
  assign busy = state == MD_BUSY;
  assign done = busy && cnt == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage MIPS pipeline.
//   Inputs : ID_Rs/ID_Rt/ID_UsesRt/ID_Branch/ID_BranchTaken/ID_MDOp describe ID;
//            ID_EX_Rt/ID_EX_WriteReg/ID_EX_RegWrite/ID_EX_MemRead describe EX;
//            EX_MDStart/EX_MDIsDiv launch a background mul/div.
//   Outputs: Stall_IF, Stall_ID, Flush_ID, Flush_EX (combinational, same cycle),
//            MD_Busy, MD_Done (MUL/DIV unit status).
//   Build option HAZARD_MDU_EN: include the MUL/DIV busy timer and its hazard;
//   without it MD_Busy=MD_Done=0 and the MD inputs are ignored.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Branch,
  input  logic       ID_BranchTaken,
  input  logic       ID_MDOp,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] ID_EX_WriteReg,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_MemRead,
  input  logic       EX_MDStart,
  input  logic       EX_MDIsDiv,
  output logic       Stall_IF,
  output logic       Stall_ID,
  output logic       Flush_ID,
  output logic       Flush_EX,
  output logic       MD_Busy,
  output logic       MD_Done
);
  logic load_use, br_haz, md_haz, stall;
  assign load_use = ID_EX_MemRead && ID_EX_Rt != REG_ZERO &&
                    (ID_EX_Rt == ID_Rs || (ID_UsesRt && ID_EX_Rt == ID_Rt));
  assign br_haz = ID_Branch && ID_EX_RegWrite && ID_EX_WriteReg != REG_ZERO &&
                  (ID_EX_WriteReg == ID_Rs || ID_EX_WriteReg == ID_Rt);
`ifdef HAZARD_MDU_EN
  md_busy_timer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md (
    .clk(clk), .rst_n(rst_n), .start(EX_MDStart), .is_div(EX_MDIsDiv),
    .busy(MD_Busy), .done(MD_Done)
  );
  // The done cycle releases the interlock so mfhi/mflo issues right away.
  assign md_haz = ID_MDOp && MD_Busy && !MD_Done;
`else
  logic unused_md;
  assign unused_md = ^{clk, ID_MDOp, EX_MDStart, EX_MDIsDiv, MUL_LAT[0], DIV_LAT[0], CNT_W[0]};
  assign md_haz = 1'b0;
  assign MD_Busy = 1'b0;
  assign MD_Done = 1'b0;
`endif
  // Outputs are forced low while reset is held.
  assign stall = rst_n && (load_use || br_haz || md_haz);
  assign Stall_IF = stall;
  assign Stall_ID = stall;
  assign Flush_EX = stall;
  assign Flush_ID = rst_n && !stall && ID_BranchTaken;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_Rs, ID_Rt, ID_EX_Rt, ID_EX_WriteReg;
  logic ID_UsesRt, ID_Branch, ID_BranchTaken, ID_MDOp;
  logic ID_EX_RegWrite, ID_EX_MemRead, EX_MDStart, EX_MDIsDiv;
  logic Stall_IF, Stall_ID, Flush_ID, Flush_EX, MD_Busy, MD_Done;
  int total = 0;
  int passed = 0;
  int rem = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_MDOp(ID_MDOp),
    .ID_EX_Rt(ID_EX_Rt), .ID_EX_WriteReg(ID_EX_WriteReg), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .EX_MDStart(EX_MDStart), .EX_MDIsDiv(EX_MDIsDiv),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done)
  );
  typedef struct {
    logic [4:0] rs, rt;
    logic uses_rt, br, taken;
    logic [4:0] ex_rt, ex_wr;
    logic rw, mr;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[12];
  function automatic logic [5:0] got_out();
    return {Stall_IF, Stall_ID, Flush_ID, Flush_EX, MD_Busy, MD_Done};
  endfunction
  function automatic logic [5:0] model_out();
    logic lu, bh, mh, st, busy, done;
    busy = MDU && rem > 0;
    done = MDU && rem == 1;
    lu = ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == ID_Rs || (ID_UsesRt && ID_EX_Rt == ID_Rt));
    bh = ID_Branch && ID_EX_RegWrite && ID_EX_WriteReg != 0 &&
         (ID_EX_WriteReg == ID_Rs || ID_EX_WriteReg == ID_Rt);
    mh = ID_MDOp && busy && !done;
    st = lu || bh || mh;
    if (!rst_n) return 6'b0;
    return {st, st, !st && ID_BranchTaken, st, busy, done};
  endfunction
  task automatic cmp(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask
  task automatic cmp_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  task automatic check(input string name);
    cmp(name, got_out(), model_out());
  endtask
  task automatic tick();
    if (!rst_n) rem = 0;
    else if (MDU && EX_MDStart) rem = EX_MDIsDiv ? DIV_L : MUL_L;
    else if (rem > 0) rem--;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    {ID_Rs, ID_Rt, ID_EX_Rt, ID_EX_WriteReg} = '0;
    {ID_UsesRt, ID_Branch, ID_BranchTaken, ID_MDOp} = '0;
    {ID_EX_RegWrite, ID_EX_MemRead, EX_MDStart, EX_MDIsDiv} = '0;
  endtask
  always @(negedge clk)
    if (rst_n && EX_MDStart) begin
      total++;
      if (MD_Busy && !MD_Done) $display("FAIL md_start_while_busy: busy=%b done=%b", MD_Busy, MD_Done);
      else passed++;
    end
  initial begin
    int busy_n, done_at, done_n;
    vecs[0]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 6'b110100};
    vecs[1]  = '{5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 6'b000000};
    vecs[2]  = '{5'd3, 5'd2, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 6'b110100};
    vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 6'b000000};
    vecs[4]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 1'b1, 1'b0, 6'b110100};
    vecs[5]  = '{5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd6, 1'b1, 1'b0, 6'b001000};
    vecs[6]  = '{5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 6'b110100};
    vecs[7]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 6'b001000};
    vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 1'b0, 6'b000000};
    vecs[9]  = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 6'b110100};
    vecs[10] = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 6'b000000};
    vecs[11] = '{5'd4, 5'd9, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 6'b000000};
    clear_in();
    rst_n = 1'b0;
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd2; ID_Rs = 5'd2; ID_BranchTaken = 1'b1;
    #2;
    cmp("reset_outputs", got_out(), 6'b0);
    tick();
    tick();
    clear_in();
    rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      ID_Rs = vecs[i].rs; ID_Rt = vecs[i].rt; ID_UsesRt = vecs[i].uses_rt;
      ID_Branch = vecs[i].br; ID_BranchTaken = vecs[i].taken;
      ID_EX_Rt = vecs[i].ex_rt; ID_EX_WriteReg = vecs[i].ex_wr;
      ID_EX_RegWrite = vecs[i].rw; ID_EX_MemRead = vecs[i].mr;
      #2;
      cmp($sformatf("vec%0d", i), got_out(), vecs[i].exp);
      tick();
    end
    clear_in();
    EX_MDStart = 1'b1; EX_MDIsDiv = 1'b1;
    #2;
    check("div_start");
    tick();
    EX_MDStart = 1'b0; EX_MDIsDiv = 1'b0; ID_MDOp = 1'b1;
    busy_n = 0; done_at = 0;
    for (int c = 1; c <= DIV_L + 3; c++) begin
      #2;
      check($sformatf("div_c%0d", c));
      if (MD_Busy) busy_n++;
      if (MD_Done) done_at = c;
      tick();
    end
    cmp_int("div_busy_cycles", busy_n, MDU ? DIV_L : 0);
    cmp_int("div_done_cycle", done_at, MDU ? DIV_L : 0);
    clear_in();
    EX_MDStart = 1'b1; EX_MDIsDiv = 1'b1;
    #2;
    tick();
    EX_MDStart = 1'b0; EX_MDIsDiv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #2;
      check($sformatf("rst_pre_c%0d", c));
      if (c < 10) tick();
    end
    ID_MDOp = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd3; ID_Rs = 5'd3; ID_BranchTaken = 1'b1;
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_op", got_out(), 6'b0);
    tick();
    clear_in();
    rst_n = 1'b1;
    ID_MDOp = 1'b1;
    done_n = 0;
    for (int c = 1; c <= DIV_L + 5; c++) begin
      #2;
      check($sformatf("rst_post_c%0d", c));
      if (MD_Done) done_n++;
      tick();
    end
    cmp_int("rst_no_done", done_n, 0);
    for (int n = 0; n < 600; n++) begin
      ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
      ID_EX_Rt = 5'($urandom_range(0, 3)); ID_EX_WriteReg = 5'($urandom_range(0, 3));
      ID_UsesRt = 1'($urandom); ID_Branch = 1'($urandom); ID_BranchTaken = 1'($urandom);
      ID_MDOp = 1'($urandom); ID_EX_RegWrite = 1'($urandom); ID_EX_MemRead = 1'($urandom);
      EX_MDIsDiv = ($urandom_range(0, 3) == 0);
      EX_MDStart = ($urandom_range(0, 5) == 0) && (rem == 0 || rem == 1);
      #2;
      check($sformatf("rand%0d", n));
      tick();
    end
    clear_in();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
